regfile_wb_ctrl: RTL and testbench

//  Writeback-side controller for the 32x32 register file; drives its set/rw_addr/rw_in write port.

---
 rtl/regfile_wb_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller for the 32x32 register file: zero sweep after reset, ALU/load merge onto
// the single write port (1-cycle registered), pending-write scoreboard, stale-read bypass flags.

// Small synchronous FIFO, combinational head; 1-cycle push-to-pop latency.
// No internal backpressure beyond count: the owner must not push while full unless also popping.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             out_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign out_vld = (count != '0);
  assign out_dat = mem[rd_ptr];
  assign do_pop  = out_rdy && out_vld;
  assign do_push = in_vld && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_nxt(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_nxt(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end
endmodule

module regfile_wb_ctrl #(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int LD_DEPTH       = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_rd,
  input  logic [XLEN-1:0]  ld_data,
  input  logic             claim_valid,
  input  logic [AW-1:0]    claim_rd,
  output logic [NREGS-1:0] busy,
  input  logic [AW-1:0]    rd1_addr,
  input  logic [AW-1:0]    rd2_addr,
  output logic             fix1_hit,
  output logic [XLEN-1:0]  fix1_data,
  output logic             fix2_hit,
  output logic [XLEN-1:0]  fix2_data,
  output logic             rf_set,
  output logic [AW-1:0]    rf_rw_addr,
  output logic [XLEN-1:0]  rf_rw_in,
  output logic             init_done
);
  typedef enum logic {CLEAR, RUN} state_t;
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] dat;
  } ld_ent_t;

  localparam int            CW        = $clog2(LD_DEPTH + 1);
  localparam state_t        RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
  localparam logic [AW:0]   CNT_END   = (AW + 1)'(NREGS);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

  state_t           state;
  logic [AW:0]      cnt;
  ld_ent_t          ld_push_dat, ld_head;
  logic             ld_push_vld, ld_head_vld, ld_pop;
  logic [CW-1:0]    ld_cnt, ld_cnt_nxt;
  logic             wr_vld;
  logic [AW-1:0]    wr_addr;
  logic [XLEN-1:0]  wr_dat;
  logic [NREGS-1:0] set_mask, clr_mask;

  wb_fifo #(.WIDTH($bits(ld_ent_t)), .DEPTH(LD_DEPTH)) u_ld_fifo (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (ld_push_vld),
    .in_dat  (ld_push_dat),
    .out_rdy (ld_pop),
    .out_vld (ld_head_vld),
    .out_dat (ld_head),
    .count   (ld_cnt)
  );

  // ALU results cannot stall, so they always win the port; rd 0 still consumes the slot.
  always_comb begin
    ld_push_vld = ld_valid && ld_ready;
    ld_push_dat = '{rd: ld_rd, dat: ld_data};
    ld_pop      = 1'b0;
    wr_vld      = 1'b0;
    wr_addr     = alu_rd;
    wr_dat      = alu_data;
    if (state == RUN) begin
      if (alu_valid) begin
        wr_vld = (alu_rd != '0);
      end else if (ld_head_vld) begin
        ld_pop  = 1'b1;
        wr_vld  = (ld_head.rd != '0);
        wr_addr = ld_head.rd;
        wr_dat  = ld_head.dat;
      end
    end
    ld_cnt_nxt = ld_cnt + CW'(ld_push_vld) - CW'(ld_pop);

    set_mask = '0;
    clr_mask = '0;
    if (state == RUN && claim_valid) set_mask[claim_rd] = 1'b1;
    if (wr_vld)                      clr_mask[wr_addr]  = 1'b1;
    set_mask[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RST_STATE;
      cnt        <= '0;
      busy       <= '0;
      ld_ready   <= 1'b0;
      init_done  <= 1'b0;
      rf_set     <= 1'b0;
      rf_rw_addr <= '0;
      rf_rw_in   <= '0;
      fix1_hit   <= 1'b0;
      fix1_data  <= '0;
      fix2_hit   <= 1'b0;
      fix2_data  <= '0;
    end else begin
      // Regfile reads land one edge after the address, alongside whatever this edge writes.
      fix1_hit  <= rf_set && (rf_rw_addr == rd1_addr) && (rd1_addr != '0);
      fix1_data <= rf_rw_in;
      fix2_hit  <= rf_set && (rf_rw_addr == rd2_addr) && (rd2_addr != '0);
      fix2_data <= rf_rw_in;
      busy      <= (busy & ~clr_mask) | set_mask;

      if (state == CLEAR) begin
        if (cnt == CNT_END) begin
          state     <= RUN;
          init_done <= 1'b1;
          ld_ready  <= 1'b1;
          rf_set    <= 1'b0;
        end else begin
          ld_ready   <= 1'b0;
          rf_set     <= 1'b1;
          rf_rw_addr <= cnt[AW-1:0];
          rf_rw_in   <= '0;
          cnt        <= cnt + CNT_ONE;
        end
      end else begin
        init_done <= 1'b1;
        ld_ready  <= (ld_cnt_nxt != CW'(LD_DEPTH));
        rf_set    <= wr_vld;
        if (wr_vld) begin
          rf_rw_addr <= wr_addr;
          rf_rw_in   <= wr_dat;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: write-port scoreboard plus directed timing checks.
module tb_regfile_wb_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        claim_valid = 1'b0;
  logic [4:0]  claim_rd = '0;
  logic [31:0] busy;
  logic [4:0]  rd1_addr = '0;
  logic [4:0]  rd2_addr = '0;
  logic        fix1_hit, fix2_hit;
  logic [31:0] fix1_data, fix2_data;
  logic        rf_set;
  logic [4:0]  rf_rw_addr;
  logic [31:0] rf_rw_in;
  logic        init_done;

  regfile_wb_ctrl dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .claim_valid(claim_valid), .claim_rd(claim_rd), .busy(busy),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .fix1_hit(fix1_hit), .fix1_data(fix1_data), .fix2_hit(fix2_hit), .fix2_data(fix2_data),
    .rf_set(rf_set), .rf_rw_addr(rf_rw_addr), .rf_rw_in(rf_rw_in), .init_done(init_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t ld_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_sweep;
    for (int i = 0; i < 32; i++) exp_q.push_back('{a: 5'(i), d: 32'h0});
  endtask

  task automatic run_sweep;
    for (int k = 1; k <= 32; k++) begin
      tick;
      check("sweep_set", rf_set, 1);
      check("sweep_init", init_done, 0);
      check("sweep_ldrdy", ld_ready, 0);
    end
    tick;
    check("init_done", init_done, 1);
    check("init_ldrdy", ld_ready, 1);
    check("init_set", rf_set, 0);
  endtask

  // Every write-port transaction must match the next expected write, in order.
  always @(negedge clock) begin
    if (!reset && rf_set) begin
      if (exp_q.size() == 0) begin
        check("spurious_wr", rf_set, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", rf_rw_addr, mon_e.a);
        check("wr_data", rf_rw_in, mon_e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick;
    tick;
    check("rst_set", rf_set, 0);
    check("rst_init", init_done, 0);
    check("rst_ldrdy", ld_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_fix1", fix1_hit, 0);
    push_sweep();
    reset = 1'b0;
    run_sweep();

    // Claim then writeback of r5
    claim_valid = 1'b1; claim_rd = 5'd5;
    tick;
    claim_valid = 1'b0;
    check("claim5", busy, 32'h0000_0020);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    exp_q.push_back('{a: 5'd5, d: 32'hDEADBEEF});
    tick;
    alu_valid = 1'b0;
    check("alu5_set", rf_set, 1);
    check("alu5_addr", rf_rw_addr, 5);
    check("busy5_clr", busy, 0);

    // ALU and load in the same cycle: ALU first, load next
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h22;
    exp_q.push_back('{a: 5'd3, d: 32'h11});
    exp_q.push_back('{a: 5'd4, d: 32'h22});
    tick;
    alu_valid = 1'b0; ld_valid = 1'b0;
    check("merge_a3", rf_rw_addr, 3);
    tick;
    check("merge_set4", rf_set, 1);
    check("merge_a4", rf_rw_addr, 4);
    tick;
    check("merge_idle", rf_set, 0);

    // Continuous ALU traffic starves the FIFO; ld_ready drops after 2 accepts
    acc = 0;
    alu_valid = 1'b1; ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h500;
    for (int i = 0; i < 6; i++) begin
      alu_rd = 5'(10 + i); alu_data = 32'hA0 + 32'(i);
      exp_q.push_back('{a: 5'(10 + i), d: 32'hA0 + 32'(i)});
      check("ld_rdy_stall", ld_ready, (i < 2) ? 1 : 0);
      if (ld_ready) begin
        ld_q.push_back('{a: ld_rd, d: ld_data});
        acc++;
      end
      tick;
      ld_rd = 5'(20 + acc); ld_data = 32'h500 + 32'(acc);
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    check("ld_accepted", acc, 2);
    while (ld_q.size() != 0) exp_q.push_back(ld_q.pop_front());
    tick;
    check("drain1_ldrdy", ld_ready, 1);
    check("drain1_a", rf_rw_addr, 20);
    tick;
    check("drain2_a", rf_rw_addr, 21);
    tick;
    check("drain_idle", rf_set, 0);

    // rd 0: dropped ALU write, dropped load, ignored claim
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    claim_valid = 1'b1; claim_rd = 5'd0;
    tick;
    alu_valid = 1'b0; claim_valid = 1'b0;
    check("x0_alu_set", rf_set, 0);
    check("x0_claim", busy, 0);
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hCAFE;
    tick;
    ld_valid = 1'b0;
    check("x0_ld_push", rf_set, 0);
    tick;
    check("x0_ld_pop", rf_set, 0);
    check("x0_ldrdy", ld_ready, 1);

    // Claim and writeback of r9 on the same edge: set wins
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    claim_valid = 1'b1; claim_rd = 5'd9;
    exp_q.push_back('{a: 5'd9, d: 32'h99});
    tick;
    alu_valid = 1'b0;
    claim_rd = 5'd8;
    check("set_wins9", busy, 32'h0000_0200);
    tick;
    claim_valid = 1'b0;
    check("claim8", busy, 32'h0000_0300);

    // Bypass: read of r7 in the cycle that writes r7
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1234;
    exp_q.push_back('{a: 5'd7, d: 32'h1234});
    tick;
    alu_valid = 1'b0;
    rd1_addr = 5'd7; rd2_addr = 5'd8;
    tick;
    rd1_addr = 5'd0; rd2_addr = 5'd0;
    check("fix1_hit", fix1_hit, 1);
    check("fix1_data", fix1_data, 32'h1234);
    check("fix2_hit", fix2_hit, 0);
    tick;
    check("fix1_clear", fix1_hit, 0);

    // Queue 2 loads behind ALU traffic, then reset mid-operation
    alu_valid = 1'b1; ld_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      alu_rd = 5'(12 + i); alu_data = 32'hB0 + 32'(i);
      ld_rd = 5'(22 + i); ld_data = 32'h700 + 32'(i);
      exp_q.push_back('{a: 5'(12 + i), d: 32'hB0 + 32'(i)});
      check("q_ldrdy", ld_ready, 1);
      tick;
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    check("q_full", ld_ready, 0);
    check("q_busy", busy, 32'h0000_0300);
    @(negedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_set", rf_set, 0);
    check("mid_rst_addr", rf_rw_addr, 0);
    check("mid_rst_in", rf_rw_in, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ldrdy", ld_ready, 0);
    check("mid_rst_init", init_done, 0);
    tick;
    push_sweep();
    reset = 1'b0;
    run_sweep();
    for (int i = 0; i < 3; i++) begin
      tick;
      check("post_rst_idle", rf_set, 0);
    end
    check("post_rst_busy", busy, 0);
    check("exp_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
